// File: rtl/sie_crc_pkg.sv
// Shared CRC16 constants, sequencer state encoding and the single-bit CRC step.
// Latency: n/a (package, no logic of its own).
// Backpressure: n/a.
// Contents: CRC16_POLY / CRC16_INIT / CRC16_RESIDUAL, state_e, crc16_step().
package sie_crc_pkg;

  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  // Remainder a receiver sees after running data plus appended CRC.
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    CRC   = 2'd3
  } state_e;

  // One bit of CRC16: feedback is the register MSB xor the incoming data bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic d);
    logic fb;
    fb = crc[15] ^ d;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial_core.sv
// Bit-serial CRC16 register: reloads to INIT on init, absorbs one bit per en.
// Latency: crc reflects an absorbed bit one cycle after en.
// Backpressure: none; the caller gates en with its own handshake.
// Ports: clk, rst (sync, high), init, en, d (data bit), crc[15:0] (current remainder).
module crc16_serial_core
  import sie_crc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic        d,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // init wins over en so a fresh packet never inherits a stale bit.
  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC16_INIT;
    end else if (en) begin
      crc_d = crc16_step(crc_q, d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc16_tx_sequencer.sv
// USB TX CRC16 sequencer: serializes payload bytes LSB-first, then the 16 inverted CRC bits.
// Latency: start -> first bit_valid in 2 cycles (LOAD, then SHIFT); 9 cycles minimum per byte.
// Backpressure: bit_ready low freezes bit_out, bit_valid and all state; tx_ready only in LOAD.
// Ports: clk/rst; start/abort control; tx_data/tx_valid/tx_last/tx_ready byte input;
//        bit_out/bit_valid/bit_ready serial output; crc_phase, busy, done, err, byte_count status.
module crc16_tx_sequencer
  import sie_crc_pkg::*;
#(
  parameter int MAX_BYTES = 1024,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  input  logic             tx_last,
  output logic             tx_ready,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             crc_phase,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] byte_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_e           state_q;
  logic [7:0]       shreg_q;
  logic             last_q;
  logic [2:0]       bit_cnt_q;
  logic [3:0]       k_q;
  logic [CNT_W-1:0] byte_count_q;
  logic             tx_ready_q;
  logic             bit_valid_q;
  logic             crc_phase_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [15:0]      crc;
  logic             crc_init;
  logic             crc_en;

  // Only payload bits feed the CRC; during CRC the remainder is held and read out.
  assign crc_init = (state_q == IDLE) && start;
  assign crc_en   = (state_q == SHIFT) && bit_ready && !abort;

  crc16_serial_core u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .d    (shreg_q[0]),
    .crc  (crc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= 8'h00;
      last_q       <= 1'b0;
      bit_cnt_q    <= 3'd0;
      k_q          <= 4'd0;
      byte_count_q <= '0;
      tx_ready_q   <= 1'b0;
      bit_valid_q  <= 1'b0;
      crc_phase_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort && (state_q != IDLE)) begin
        // byte_count deliberately kept so software can see how far the packet got.
        state_q     <= IDLE;
        tx_ready_q  <= 1'b0;
        bit_valid_q <= 1'b0;
        crc_phase_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              byte_count_q <= '0;
              bit_cnt_q    <= 3'd0;
              k_q          <= 4'd0;
              busy_q       <= 1'b1;
              if (tx_last && !tx_valid) begin
                // Zero-length packet: nothing to load, go straight to the CRC field.
                state_q     <= CRC;
                bit_valid_q <= 1'b1;
                crc_phase_q <= 1'b1;
              end else begin
                state_q    <= LOAD;
                tx_ready_q <= 1'b1;
              end
            end
          end
          LOAD: begin
            if (tx_valid) begin
              tx_ready_q <= 1'b0;
              if (byte_count_q == MAX_CNT) begin
                // A byte beyond the limit kills the packet before any CRC goes out.
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                shreg_q      <= tx_data;
                last_q       <= tx_last;
                byte_count_q <= byte_count_q + ONE_CNT;
                bit_cnt_q    <= 3'd0;
                bit_valid_q  <= 1'b1;
                state_q      <= SHIFT;
              end
            end
          end
          SHIFT: begin
            if (bit_ready) begin
              shreg_q   <= {1'b0, shreg_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (last_q) begin
                  k_q         <= 4'd0;
                  crc_phase_q <= 1'b1;
                  state_q     <= CRC;
                end else begin
                  bit_valid_q <= 1'b0;
                  tx_ready_q  <= 1'b1;
                  state_q     <= LOAD;
                end
              end
            end
          end
          CRC: begin
            if (bit_ready) begin
              k_q <= k_q + 4'd1;
              if (k_q == 4'd15) begin
                done_q      <= 1'b1;
                bit_valid_q <= 1'b0;
                crc_phase_q <= 1'b0;
                busy_q      <= 1'b0;
                state_q     <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // bit_out is a pure mux of registers: current payload LSB or inverted remainder, MSB first.
  assign bit_out    = (state_q == SHIFT) ? shreg_q[0] :
                      (state_q == CRC)   ? ~crc[4'd15 - k_q] : 1'b0;
  assign tx_ready   = tx_ready_q;
  assign bit_valid  = bit_valid_q;
  assign crc_phase  = crc_phase_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_crc16_tx_sequencer.sv
// Bench for crc16_tx_sequencer: directed and random packets against a byte-wise CRC-16/USB model.
// Latency: n/a.
// Backpressure: bit_ready is either held high or randomised per cycle.
module tb_crc16_tx_sequencer;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst, start, abort, tx_valid, tx_last, bit_ready, sel;
  logic [7:0] tx_data;

  // Instance A: full-size packets. Instance B: MAX_BYTES = 4 for the overflow case.
  logic a_start, a_tx_valid, b_start, b_tx_valid;
  logic a_tx_ready, a_bit_out, a_bit_valid, a_crc_phase, a_busy, a_done, a_err;
  logic b_tx_ready, b_bit_out, b_bit_valid, b_crc_phase, b_busy, b_done, b_err;
  logic [10:0] a_byte_count, b_byte_count;
  logic tx_ready_m, bit_out_m, bit_valid_m, crc_phase_m, busy_m, done_m, err_m;
  logic [10:0] byte_count_m;

  assign a_start    = start & ~sel;
  assign a_tx_valid = tx_valid & ~sel;
  assign b_start    = start & sel;
  assign b_tx_valid = tx_valid & sel;

  assign tx_ready_m   = sel ? b_tx_ready   : a_tx_ready;
  assign bit_out_m    = sel ? b_bit_out    : a_bit_out;
  assign bit_valid_m  = sel ? b_bit_valid  : a_bit_valid;
  assign crc_phase_m  = sel ? b_crc_phase  : a_crc_phase;
  assign busy_m       = sel ? b_busy       : a_busy;
  assign done_m       = sel ? b_done       : a_done;
  assign err_m        = sel ? b_err        : a_err;
  assign byte_count_m = sel ? b_byte_count : a_byte_count;

  crc16_tx_sequencer #(.MAX_BYTES(1024), .CNT_W(11)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(abort),
    .tx_data(tx_data), .tx_valid(a_tx_valid), .tx_last(tx_last), .tx_ready(a_tx_ready),
    .bit_out(a_bit_out), .bit_valid(a_bit_valid), .bit_ready(bit_ready),
    .crc_phase(a_crc_phase), .busy(a_busy), .done(a_done), .err(a_err),
    .byte_count(a_byte_count)
  );

  crc16_tx_sequencer #(.MAX_BYTES(4), .CNT_W(11)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(abort),
    .tx_data(tx_data), .tx_valid(b_tx_valid), .tx_last(tx_last), .tx_ready(b_tx_ready),
    .bit_out(b_bit_out), .bit_valid(b_bit_valid), .bit_ready(bit_ready),
    .crc_phase(b_crc_phase), .busy(b_busy), .done(b_done), .err(b_err),
    .byte_count(b_byte_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;

  // Captured per packet.
  logic pay_bits[$];
  logic crc_bits[$];
  int ndone, nerr, first_vld, done_cyc, start_cyc;
  logic prev_stall, prev_bit, hs;
  logic [15:0] last_crc_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: textbook reflected CRC-16/USB over whole bytes (poly A001, init/xorout FFFF).
  // Bit k of the result is the k-th CRC bit on the wire.
  function automatic logic [15:0] usb_crc(input byte_q_t d);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (d[i]) begin
      c = c ^ {8'h00, d[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic clr();
    pay_bits.delete();
    crc_bits.delete();
    ndone = 0; nerr = 0; first_vld = -1; done_cyc = -1;
    prev_stall = 1'b0; prev_bit = 1'b0; hs = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
    if (prev_stall)
      chk("stall_hold", {30'd0, bit_valid_m, bit_out_m}, {30'd0, 1'b1, prev_bit});
    if (bit_valid_m && first_vld < 0) first_vld = cyc;
    if (bit_valid_m && bit_ready) begin
      if (crc_phase_m) crc_bits.push_back(bit_out_m);
      else             pay_bits.push_back(bit_out_m);
    end
    if (done_m) begin ndone++; done_cyc = cyc; end
    if (err_m) nerr++;
    hs = tx_valid && tx_ready_m;
    prev_stall = bit_valid_m && !bit_ready;
    prev_bit = bit_out_m;
  endtask

  // Drives one packet until done/err, or aborts once abort_at CRC bits have gone out.
  task automatic send_packet(input byte_q_t d, input bit stall, input int abort_at);
    int n, idx;
    bit fin;
    n = d.size(); idx = 0; fin = 1'b0;
    clr();
    @(posedge clk); #1;
    start = 1'b1;
    tx_valid = (n > 0);
    tx_data = (n > 0) ? d[0] : 8'h00;
    tx_last = (n <= 1);
    bit_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    start_cyc = cyc;
    for (int budget = 0; budget < 3000 && !fin; budget++) begin
      sample();
      if (ndone > 0 || nerr > 0) begin
        fin = 1'b1;
      end else if (abort_at >= 0 && crc_phase_m && crc_bits.size() == abort_at) begin
        @(posedge clk); #1;
        abort = 1'b1; start = 1'b0; tx_valid = 1'b0; tx_last = 1'b0; bit_ready = 1'b1;
        sample();
        @(posedge clk); #1;
        abort = 1'b0;
        sample();
        fin = 1'b1;
      end else begin
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) tx_last = 1'b0;
        if (hs) begin
          idx++;
          if (idx < n) begin
            tx_data = d[idx];
            tx_last = (idx == n - 1);
          end else begin
            tx_valid = 1'b0;
            tx_last = 1'b0;
          end
        end
        bit_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    chk("pkt_finished", {31'd0, fin}, 32'd1);
    start = 1'b0; tx_valid = 1'b0; tx_last = 1'b0; bit_ready = 1'b1;
  endtask

  task automatic check_packet(input string tag, input byte_q_t d);
    int bad;
    last_crc_val = 16'h0000;
    chk({tag, "_paylen"}, pay_bits.size(), d.size() * 8);
    bad = 0;
    foreach (d[i])
      for (int b = 0; b < 8; b++)
        if (8 * i + b >= pay_bits.size() || pay_bits[8 * i + b] !== d[i][b]) bad++;
    chk({tag, "_paybits_bad"}, bad, 0);
    chk({tag, "_crclen"}, crc_bits.size(), 16);
    foreach (crc_bits[k]) if (k < 16) last_crc_val[k] = crc_bits[k];
    chk({tag, "_crc"}, {16'd0, last_crc_val}, {16'd0, usb_crc(d)});
    chk({tag, "_done_cnt"}, ndone, 1);
    chk({tag, "_busy_after"}, {31'd0, busy_m}, 0);
    chk({tag, "_byte_count"}, {21'd0, byte_count_m}, d.size());
  endtask

  function automatic int stream_diff(input logic a[$], input logic b[$]);
    int bad;
    bad = (a.size() == b.size()) ? 0 : 1;
    foreach (a[i]) if (i < b.size() && a[i] !== b[i]) bad++;
    return bad;
  endfunction

  initial begin
    byte_q_t pk;
    logic ref_pay[$];
    logic ref_crc[$];
    int saved_cnt;

    rst = 1'b1; start = 1'b0; abort = 1'b0; tx_valid = 1'b0; tx_last = 1'b0;
    tx_data = 8'h00; bit_ready = 1'b1; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_a", {25'd0, tx_ready_m, bit_valid_m, bit_out_m, crc_phase_m, busy_m, done_m, err_m}, 0);
    chk("reset_byte_count_a", {21'd0, byte_count_m}, 0);
    chk("reset_outputs_b", {25'd0, b_tx_ready, b_bit_valid, b_bit_out, b_crc_phase, b_busy, b_done, b_err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero-length packet: CRC of nothing is ~FFFF = all zeros on the wire.
    pk = {};
    send_packet(pk, 1'b0, -1);
    check_packet("zlen", pk);
    chk("zlen_crc_zero", {16'd0, last_crc_val}, 0);

    // Single 0x00 byte, no stalls.
    pk = {8'h00};
    send_packet(pk, 1'b0, -1);
    check_packet("b00", pk);
    chk("b00_crc_const", {16'd0, last_crc_val}, 32'h0000_BF40);
    chk("b00_start_latency", first_vld - start_cyc, 2);
    // done appears in the 25th cycle counting the first bit_valid cycle as cycle 1.
    chk("b00_done_timing", done_cyc - first_vld, 24);

    // Standard check string.
    pk = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_packet(pk, 1'b0, -1);
    check_packet("ascii9", pk);
    chk("ascii9_crc_const", {16'd0, last_crc_val}, 32'h0000_B4C8);

    // Same random 4 bytes with and without stalls must give identical streams.
    pk = {};
    repeat (4) pk.push_back(8'($urandom));
    send_packet(pk, 1'b0, -1);
    check_packet("r4_nostall", pk);
    ref_pay = pay_bits;
    ref_crc = crc_bits;
    send_packet(pk, 1'b1, -1);
    check_packet("r4_stall", pk);
    chk("r4_stream_same", stream_diff(pay_bits, ref_pay) + stream_diff(crc_bits, ref_crc), 0);

    // Random lengths and random backpressure.
    for (int p = 0; p < 4; p++) begin
      pk = {};
      repeat ($urandom_range(1, 6)) pk.push_back(8'($urandom));
      send_packet(pk, 1'($urandom_range(0, 1)), -1);
      check_packet("rand_pkt", pk);
    end

    // Abort while CRC bit 5 is on the wire, then a fresh packet.
    pk = {8'($urandom), 8'($urandom)};
    send_packet(pk, 1'b0, 5);
    chk("abort_outputs", {25'd0, tx_ready_m, bit_valid_m, bit_out_m, crc_phase_m, busy_m, done_m, err_m}, 0);
    chk("abort_no_done", ndone, 0);
    chk("abort_byte_count", {21'd0, byte_count_m}, 2);
    pk = {8'($urandom), 8'($urandom), 8'($urandom)};
    send_packet(pk, 1'b0, -1);
    check_packet("after_abort", pk);

    // Overflow on the MAX_BYTES = 4 instance.
    sel = 1'b1;
    pk = {};
    repeat (5) pk.push_back(8'($urandom));
    send_packet(pk, 1'b0, -1);
    chk("ovf_err_cnt", nerr, 1);
    chk("ovf_no_done", ndone, 0);
    chk("ovf_no_crc_bits", crc_bits.size(), 0);
    chk("ovf_paylen", pay_bits.size(), 32);
    chk("ovf_busy", {31'd0, busy_m}, 0);
    chk("ovf_byte_count", {21'd0, byte_count_m}, 4);
    sel = 1'b0;

    // Reset in the middle of a byte.
    saved_cnt = total;
    @(posedge clk); #1;
    start = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5; tx_last = 1'b1; bit_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_last = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_shift", {30'd0, bit_valid_m, busy_m}, 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_outputs", {25'd0, tx_ready_m, bit_valid_m, bit_out_m, crc_phase_m, busy_m, done_m, err_m}, 0);
    chk("rst_mid_byte_count", {21'd0, byte_count_m}, 0);
    rst = 1'b0;
    chk("rst_block_ran", total - saved_cnt, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
